// File: rtl/puf_rng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_rng_pkg
// Description : Shared types and default constants for the PUF RNG collector.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_rng_pkg;

    // Collector control state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FAIL    = 2'd2
    } rng_col_state_t;

    localparam int RNG_WORD_W     = 32;
    localparam int RNG_FIFO_DEPTH = 4;
    localparam int RNG_REP_LIMIT  = 8;

    // Width needed to count 0..depth words
    function automatic int rng_level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : puf_rng_pkg
`default_nettype wire

// File: rtl/puf_rng_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : puf_rng_collector_if
// Description : Entropy-word stream from the collector FIFO to the register
//               block (valid/ready plus occupancy).
// Revision    : 1.0 - initial release
// ============================================================================
interface puf_rng_collector_if
    import puf_rng_pkg::*;
#(
    parameter int WORD_W     = RNG_WORD_W,
    parameter int FIFO_DEPTH = RNG_FIFO_DEPTH
);
    localparam int LEVEL_W = rng_level_w(FIFO_DEPTH);

    logic               word_valid;
    logic               word_ready;
    logic [WORD_W-1:0]  word_data;
    logic [LEVEL_W-1:0] fifo_level;

    // Collector side
    modport master (
        output word_valid,
        output word_data,
        output fifo_level,
        input  word_ready
    );

    // Consumer side
    modport slave (
        input  word_valid,
        input  word_data,
        input  fifo_level,
        output word_ready
    );

endinterface : puf_rng_collector_if
`default_nettype wire

// File: rtl/puf_rng_fifo.sv
`default_nettype none
// ============================================================================
// Module      : puf_rng_fifo
// Description : Small register FIFO with push, pop and flush. Head reads 0
//               when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_rng_fifo
    import puf_rng_pkg::*;
#(
    parameter int WIDTH = RNG_WORD_W,
    parameter int DEPTH = RNG_FIFO_DEPTH
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          push,
    input  wire logic                          pop,
    input  wire logic                          flush,
    input  wire logic [WIDTH-1:0]              wdata,
    output logic                               full,
    output logic                               empty,
    output logic [rng_level_w(DEPTH)-1:0]      level,
    output logic [WIDTH-1:0]                   head
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = rng_level_w(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_level == LEVEL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign head      = empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage, pointers and occupancy; flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + LEVEL_W'(w_do_push) - LEVEL_W'(w_do_pop);
        end
    end

endmodule : puf_rng_fifo
`default_nettype wire

// File: rtl/puf_rng_collector.sv
`default_nettype none
// ============================================================================
// Module      : puf_rng_collector
// Description : Requests nibbles from the PUF RNG, packs them MSB-first into
//               words, runs a repetition-count health test and queues words
//               for the entropy-source register block.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_rng_collector
    import puf_rng_pkg::*;
#(
    parameter int WORD_W     = RNG_WORD_W,
    parameter int FIFO_DEPTH = RNG_FIFO_DEPTH,
    parameter int REP_LIMIT  = RNG_REP_LIMIT
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        enable,
    input  wire logic        clear_fail,
    input  wire logic [3:0]  rng4bit,
    input  wire logic        rng4bit_done,
    output logic             es_rng_req,
    output logic             health_fail,
    puf_rng_collector_if.master word_if
);
    localparam int NIB_PER_WORD = WORD_W / 4;
    localparam int NIB_W        = (NIB_PER_WORD > 1) ? $clog2(NIB_PER_WORD) : 1;
    localparam int LEVEL_W      = rng_level_w(FIFO_DEPTH);

    localparam logic [NIB_W-1:0] c_LAST_NIB  = NIB_W'(NIB_PER_WORD - 1);
    localparam logic [3:0]       c_REP_LIMIT = 4'(REP_LIMIT);

    rng_col_state_t    r_state;
    logic [WORD_W-1:0] r_shift;
    logic [NIB_W-1:0]  r_nib_cnt;
    logic [3:0]        r_rep_cnt;
    logic [3:0]        r_last;

    logic               w_full;
    logic               w_empty;
    logic [LEVEL_W-1:0] w_level;
    logic [WORD_W-1:0]  w_head;
    logic [WORD_W-1:0]  w_next_word;
    logic               w_accept;
    logic               w_same;
    logic [3:0]         w_rep_next;
    logic               w_rep_hit;
    logic               w_last_nib;
    logic               w_push;
    logic               w_pop;

    assign es_rng_req  = (r_state == ST_COLLECT) && !w_full;
    assign health_fail = (r_state == ST_FAIL);

    assign w_accept    = rng4bit_done && es_rng_req;
    assign w_next_word = {r_shift[WORD_W-5:0], rng4bit};
    assign w_last_nib  = (r_nib_cnt == c_LAST_NIB);
    // rep_cnt of 0 marks "no nibble seen since leaving IDLE/FAIL"
    assign w_same      = (r_rep_cnt != 4'd0) && (rng4bit == r_last);
    assign w_rep_next  = r_rep_cnt + 4'd1;
    assign w_rep_hit   = w_accept && w_same && (w_rep_next == c_REP_LIMIT);

    // A nibble seen on the same edge that enable drops is discarded with the
    // partial word, so it never completes a word either.
    assign w_push = w_accept && enable && w_last_nib && !w_rep_hit;
    assign w_pop  = word_if.word_valid && word_if.word_ready;

    assign word_if.word_valid = !w_empty;
    assign word_if.word_data  = w_head;
    assign word_if.fifo_level = w_level;

    puf_rng_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_rep_hit),
        .wdata (w_next_word),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level),
        .head  (w_head)
    );

    // Control FSM with nibble packing and repetition-count tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_nib_cnt <= '0;
            r_rep_cnt <= '0;
            r_last    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_rep_hit || !enable) begin
                        r_state   <= w_rep_hit ? ST_FAIL : ST_IDLE;
                        r_shift   <= '0;
                        r_nib_cnt <= '0;
                        r_rep_cnt <= '0;
                        r_last    <= '0;
                    end else if (w_accept) begin
                        r_rep_cnt <= w_same ? w_rep_next : 4'd1;
                        r_last    <= rng4bit;
                        if (w_last_nib) begin
                            r_shift   <= '0;
                            r_nib_cnt <= '0;
                        end else begin
                            r_shift   <= w_next_word;
                            r_nib_cnt <= r_nib_cnt + 1'b1;
                        end
                    end
                end
                ST_FAIL: begin
                    if (clear_fail) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : puf_rng_collector
`default_nettype wire
